t_ff_up_counter: RTL and testbench
==================================

# t_ff_up_counter

Synchronous up counter built from T flip-flops. It is the counting-up counterpart to the team's ripple down counter, and all bits toggle on the same `clk` edge (no ripple). The modulus is programmable. The `T` input pauses counting without losing the count, and a terminal-count output supports cascading. An optional one-shot mode counts one full cycle and stops. The block serves as the standard up-count/timer primitive in lab designs and cascaded counter chains.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `MOD`, default 16: count modulus, legal range 2 ≤ MOD ≤ 2^WIDTH. The count runs 0..MOD-1.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `T`  input  1  count enable. 1 = count, 0 = pause and hold `q`.
- `mode`  input  1  0 = free-run, 1 = one-shot.
- `start`  input  1  one-shot start request (level sampled on the edge).
- `load`  input  1  parallel-load strobe (present only with `UPCNT_LOAD_EN`).
- `d`  input  WIDTH  parallel-load value (present only with `UPCNT_LOAD_EN`).
- `q`  output  WIDTH  registered count.
- `tc`  output  1  combinational terminal count, for cascading.
- `busy`  output  1  registered; high while the one-shot counter is in RUN.
- `done`  output  1  registered one-cycle pulse marking one-shot completion.

## Operation
- **Increment structure:** each bit i is a T flip-flop. Bit i toggles when the count is enabled and bits 0..i-1 are all 1.
- **Wrap (MOD < 2^WIDTH):** when q = MOD-1 and an increment occurs, q is forced to 0.
- **Free-run (`mode`=0):**
  - q increments on every edge where T=1.
  - Wraps MOD-1 → 0.
  - `start` is ignored; `busy`=0; `done`=0.
- **One-shot (`mode`=1), FSM states IDLE, RUN, DONE:**
  - IDLE: q holds. If `start`=1, then q←0 and state←RUN.
  - RUN: q increments when T=1. At an edge where q = MOD-1 and T=1, q holds at MOD-1, state←DONE, and `done`=1 for that one cycle. `start` is ignored in RUN.
  - DONE: q holds at MOD-1. If `start`=1, then q←0 and state←RUN (restart). Otherwise DONE persists.
- **Mode change:** a `mode` transition 0→1 puts the FSM in IDLE at the next edge with q held. A transition 1→0 resumes free-run from the current q.
- **Terminal count:** `tc` = T & (q == MOD-1) & (`mode`=0 | state==RUN).
- **Priority on an edge:** load > start > count.

## Timing
- **Reset (`rst`=0, asynchronous):** q=0, state=IDLE, `busy`=0, `done`=0. These values hold while `rst`=0. Counting starts on the first rising edge after release.
- **Latency:** every input takes effect at the next rising edge. `tc` is combinational, with zero latency.
- **Pause:** T=0 holds q indefinitely. When T returns to 1, counting resumes from the held value, with no skipped or repeated count.
- **Reset mid-operation:** `rst`=0 at any time, including during RUN or while `done`=1, returns all outputs to their reset values immediately.
- **Cascading:** a downstream stage's `T` connects to the upstream `tc`. The downstream stage then increments exactly on the upstream wrap edge.
- **`done`:** high exactly one clock period per completed one-shot. It never asserts in free-run.

## Configuration
- **`UPCNT_LOAD_EN` defined:** the `load` and `d` ports exist.
  - `load`=1 sets q←d at the next edge, regardless of T, mode or state.
  - If d ≥ MOD, q←MOD-1.
  - Load does not change the FSM state and does not assert `done`.
  - Load takes priority over `start` and counting on the same edge.
- **`UPCNT_LOAD_EN` not defined:** `load` and `d` are absent. The count can only be set by reset, by wrap, or by `start` (which clears it to 0).

## Test plan
- **Free-run, pause, resume, reset** (WIDTH=4, MOD=16): `rst`=0, release at 15 ns (10 ns clock period), T=1, `mode`=0.
  - q counts 0,1,2,… from the first edge.
  - T=0 for 5 cycles → q frozen.
  - T=1 → q continues from the frozen value +1.
  - `rst`=0 mid-count → q=0 immediately.
- **Modulus wrap** (MOD=10, T=1): q runs 0..9, then 0.
  - `tc`=1 only while q=9.
  - A cascaded second stage increments once per 10 cycles.
- **One-shot** (MOD=10, `mode`=1): a `start` pulse moves IDLE→RUN with q=0.
  - q counts to 9 and holds at 9.
  - `done`=1 for exactly one cycle; `busy` 1→0.
  - A second `start` → q=0, and the counter runs again.
- **One-shot with pause:** T=0 for 3 cycles during RUN at q=4.
  - q holds at 4 and `busy` stays 1.
  - Completion is delayed by exactly 3 cycles.
- **Load** (`UPCNT_LOAD_EN` defined, MOD=10):
  - `load`=1 with d=7 → q=7 at the next edge.
  - d=12 → q=9.
  - `load` and `start` on the same edge in IDLE → q=d, state stays IDLE.
- **Reset during DONE:** `rst`=0 while `done`=1 → `done`=0, q=0, state IDLE. The next `start` restarts the count from 0.

Source files
------------

// File: rtl/t_ff_up_counter.sv
// t_ff_up_counter: synchronous T-flip-flop up counter with programmable modulus, pause,
// cascade terminal count and a one-shot mode. Optional parallel load: UPCNT_LOAD_EN.
module t_ff_up_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             T,
  input  logic             mode,
  input  logic             start,
`ifdef UPCNT_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] d,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MOD);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] tog;
  logic [WIDTH-1:0] q_wrap;
  logic             at_last;
  logic             done_nx;

  // Bit i toggles when counting is enabled and every lower bit is 1; all bits share clk.
  for (genvar i = 0; i < WIDTH; i++) begin : g_tff
    if (i == 0) begin : g_lsb
      assign tog[i] = T;
    end else begin : g_upper
      assign tog[i] = T & (&q[i-1:0]);
    end
  end

  always_comb begin
    at_last = (q == LAST);
    q_wrap  = at_last ? '0 : (q ^ tog);
  end

`ifdef UPCNT_LOAD_EN
  logic [WIDTH-1:0] load_val;

  always_comb begin
    load_val = ({1'b0, d} >= MOD_X) ? LAST : d;
  end
`endif

  always_comb begin
    state_nx = state;
    q_nx     = q;
    done_nx  = 1'b0;
    if (!mode) begin
      // free-run parks the FSM in IDLE so a later switch to one-shot waits for start
      state_nx = ST_IDLE;
      if (T) begin
        q_nx = q_wrap;
      end
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            q_nx     = '0;
            state_nx = ST_RUN;
          end
        end
        ST_RUN: begin
          if (T) begin
            if (at_last) begin
              state_nx = ST_DONE;
              done_nx  = 1'b1;
            end else begin
              q_nx = q ^ tog;
            end
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
`ifdef UPCNT_LOAD_EN
    // load overrides start and counting but leaves the one-shot state untouched
    if (load) begin
      q_nx    = load_val;
      done_nx = 1'b0;
      if (mode) begin
        state_nx = state;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      q     <= q_nx;
      busy  <= (state_nx == ST_RUN);
      done  <= done_nx;
    end
  end

  always_comb begin
    tc = T & at_last & (~mode | (state == ST_RUN));
  end

  a_done_not_busy: assert property (@(posedge clk) disable iff (!rst) done |-> !busy);
  a_q_in_range:    assert property (@(posedge clk) disable iff (!rst) q <= LAST);
  a_no_done_free:  assert property (@(posedge clk) disable iff (!rst) !mode |=> !done);

endmodule

// File: tb/tb_t_ff_up_counter.sv
// Bench for t_ff_up_counter: MOD=16 stage, MOD=10 stage and a cascaded MOD=10 stage,
// checked every cycle against an arithmetic model plus directed literal checkpoints.
module tb_t_ff_up_counter;

  localparam int IDLE_S = 0;
  localparam int RUN_S  = 1;
  localparam int DONE_S = 2;

  logic       clk;
  logic       rst16, t16;
  logic       rstA, tA, modeA, startA;
  logic [3:0] q16, qA, qB;
  logic       tc16, tcA, tcB;
  logic       busy16, busyA, busyB;
  logic       done16, doneA, doneB;
`ifdef UPCNT_LOAD_EN
  logic       loadA;
  logic [3:0] dA;
`endif

  int checks = 0;
  int errors = 0;

  int m_q[3];
  int m_st[3];
  bit m_busy[3];
  bit m_done[3];
  int mods[3] = '{16, 10, 10};

  t_ff_up_counter #(.WIDTH(4), .MOD(16)) u16 (
    .clk(clk), .rst(rst16), .T(t16), .mode(1'b0), .start(1'b0),
`ifdef UPCNT_LOAD_EN
    .load(1'b0), .d(4'd0),
`endif
    .q(q16), .tc(tc16), .busy(busy16), .done(done16)
  );

  t_ff_up_counter #(.WIDTH(4), .MOD(10)) uA (
    .clk(clk), .rst(rstA), .T(tA), .mode(modeA), .start(startA),
`ifdef UPCNT_LOAD_EN
    .load(loadA), .d(dA),
`endif
    .q(qA), .tc(tcA), .busy(busyA), .done(doneA)
  );

  t_ff_up_counter #(.WIDTH(4), .MOD(10)) uB (
    .clk(clk), .rst(rstA), .T(tcA), .mode(1'b0), .start(1'b0),
`ifdef UPCNT_LOAD_EN
    .load(1'b0), .d(4'd0),
`endif
    .q(qB), .tc(tcB), .busy(busyB), .done(doneB)
  );

  initial begin
    clk = 1'b0;
    #5;
    forever begin
      #5 clk = ~clk;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit exp_tc(input int k, input bit t, input bit md);
    return t && (m_q[k] == mods[k] - 1) && (!md || m_st[k] == RUN_S);
  endfunction

  task automatic step(input int k, input bit rs, input bit t, input bit md, input bit st,
                      input bit ld, input int dv);
    if (!rs) begin
      m_q[k]    = 0;
      m_st[k]   = IDLE_S;
      m_busy[k] = 1'b0;
      m_done[k] = 1'b0;
    end else begin
      m_done[k] = 1'b0;
      if (ld) begin
        m_q[k] = (dv >= mods[k]) ? mods[k] - 1 : dv;
        if (!md) m_st[k] = IDLE_S;
      end else if (!md) begin
        m_st[k] = IDLE_S;
        if (t) m_q[k] = (m_q[k] + 1) % mods[k];
      end else if (m_st[k] == RUN_S) begin
        if (t && m_q[k] == mods[k] - 1) begin
          m_st[k]   = DONE_S;
          m_done[k] = 1'b1;
        end else if (t) begin
          m_q[k]++;
        end
      end else if (st) begin
        m_q[k]  = 0;
        m_st[k] = RUN_S;
      end
      m_busy[k] = (m_st[k] == RUN_S);
    end
  endtask

  task automatic cmp_all();
    bit e_tc16, e_tcA, e_tcB;
    e_tc16 = exp_tc(0, t16, 1'b0);
    e_tcA  = exp_tc(1, tA, modeA);
    e_tcB  = exp_tc(2, e_tcA, 1'b0);
    chk("q16",    int'(q16),    m_q[0]);
    chk("tc16",   int'(tc16),   int'(e_tc16));
    chk("busy16", int'(busy16), int'(m_busy[0]));
    chk("done16", int'(done16), int'(m_done[0]));
    chk("qA",     int'(qA),     m_q[1]);
    chk("tcA",    int'(tcA),    int'(e_tcA));
    chk("busyA",  int'(busyA),  int'(m_busy[1]));
    chk("doneA",  int'(doneA),  int'(m_done[1]));
    chk("qB",     int'(qB),     m_q[2]);
    chk("tcB",    int'(tcB),    int'(e_tcB));
    chk("busyB",  int'(busyB),  int'(m_busy[2]));
    chk("doneB",  int'(doneB),  int'(m_done[2]));
  endtask

  // Model advances on each rising edge from the inputs held since the previous falling edge.
  always @(posedge clk) begin
    bit tca_pre;
    bit ld_a;
    int dv_a;
    ld_a = 1'b0;
    dv_a = 0;
`ifdef UPCNT_LOAD_EN
    ld_a = loadA;
    dv_a = int'(dA);
`endif
    tca_pre = exp_tc(1, tA, modeA);
    step(0, rst16, t16, 1'b0, 1'b0, 1'b0, 0);
    step(1, rstA, tA, modeA, startA, ld_a, dv_a);
    step(2, rstA, tca_pre, 1'b0, 1'b0, 1'b0, 0);
    #1;
    cmp_all();
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst16 = 1'b0; t16 = 1'b1;
    rstA = 1'b0; tA = 1'b1; modeA = 1'b0; startA = 1'b0;
`ifdef UPCNT_LOAD_EN
    loadA = 1'b0; dA = 4'd0;
`endif
    @(posedge clk);
    @(negedge clk);
    chk("lit q16 in reset", int'(q16), 0);
    chk("lit busyA in reset", int'(busyA), 0);
    chk("lit doneA in reset", int'(doneA), 0);
    rst16 = 1'b1; rstA = 1'b1;

    // free-run, pause, resume, async reset
    cycles(3);  chk("lit q16 count", int'(q16), 3);
    t16 = 1'b0;
    cycles(5);  chk("lit q16 paused", int'(q16), 3);
    t16 = 1'b1;
    cycles(1);  chk("lit q16 resume", int'(q16), 4);
    cycles(11); chk("lit q16 last", int'(q16), 15); chk("lit tc16 last", int'(tc16), 1);
    cycles(1);  chk("lit q16 wrap", int'(q16), 0);  chk("lit tc16 wrap", int'(tc16), 0);
    cycles(4);
    #2 rst16 = 1'b0;
    #1 chk("lit q16 async reset", int'(q16), 0);
    @(negedge clk); rst16 = 1'b1;
    cycles(2);  chk("lit q16 after reset", int'(q16), 2);

    // modulus-10 wrap and cascade
    rstA = 1'b0;
    @(negedge clk); rstA = 1'b1;
    cycles(9);  chk("lit qA 9", int'(qA), 9); chk("lit tcA at 9", int'(tcA), 1); chk("lit qB 0", int'(qB), 0);
    cycles(1);  chk("lit qA wrap", int'(qA), 0); chk("lit tcA at 0", int'(tcA), 0); chk("lit qB 1", int'(qB), 1);
    cycles(9);
    cycles(1);  chk("lit qB 2", int'(qB), 2); chk("lit tcB low", int'(tcB), 0);
    cycles(79); chk("lit qB 9", int'(qB), 9); chk("lit tcB high", int'(tcB), 1);
    cycles(1);  chk("lit qA 100", int'(qA), 0); chk("lit qB wrap", int'(qB), 0);

    // one-shot
    modeA = 1'b1; rstA = 1'b0;
    @(negedge clk); rstA = 1'b1;
    cycles(2);  chk("lit idle qA", int'(qA), 0); chk("lit idle busy", int'(busyA), 0);
    startA = 1'b1;
    cycles(1);  chk("lit run q0", int'(qA), 0); chk("lit run busy", int'(busyA), 1);
    startA = 1'b0;
    cycles(9);  chk("lit run q9", int'(qA), 9); chk("lit run tc", int'(tcA), 1); chk("lit run done low", int'(doneA), 0);
    cycles(1);  chk("lit done pulse", int'(doneA), 1); chk("lit done q9", int'(qA), 9); chk("lit done busy", int'(busyA), 0);
    cycles(1);  chk("lit done cleared", int'(doneA), 0);
    cycles(3);  chk("lit done hold", int'(qA), 9); chk("lit done tc", int'(tcA), 0);
    startA = 1'b1;
    cycles(1);  chk("lit restart q0", int'(qA), 0); chk("lit restart busy", int'(busyA), 1);
    startA = 1'b0;

    // start ignored in RUN, pause at 4
    cycles(2);  startA = 1'b1;
    cycles(1);  chk("lit start in run", int'(qA), 3);
    startA = 1'b0;
    cycles(1);  chk("lit run q4", int'(qA), 4);
    tA = 1'b0;
    cycles(3);  chk("lit pause q4", int'(qA), 4); chk("lit pause busy", int'(busyA), 1);
    tA = 1'b1;
    cycles(5);  chk("lit delayed q9", int'(qA), 9); chk("lit delayed no done", int'(doneA), 0);
    cycles(1);  chk("lit delayed done", int'(doneA), 1);

    // reset while done is high
    #2 rstA = 1'b0;
    #1 chk("lit rst done", int'(doneA), 0); chk("lit rst q", int'(qA), 0); chk("lit rst busy", int'(busyA), 0);
    @(negedge clk); rstA = 1'b1;
    cycles(2);  chk("lit post-rst idle", int'(qA), 0); chk("lit post-rst busy", int'(busyA), 0);
    startA = 1'b1;
    cycles(1);  chk("lit post-rst start", int'(busyA), 1);
    startA = 1'b0;
    cycles(3);  chk("lit post-rst q3", int'(qA), 3);

    // mode changes
    modeA = 1'b0;
    cycles(1);  chk("lit free resume", int'(qA), 4); chk("lit free busy", int'(busyA), 0);
    cycles(5);  chk("lit free q9", int'(qA), 9);
    cycles(1);  chk("lit free wrap", int'(qA), 0); chk("lit free no done", int'(doneA), 0);
    cycles(2);
    modeA = 1'b1;
    cycles(1);  chk("lit to oneshot hold", int'(qA), 2); chk("lit to oneshot busy", int'(busyA), 0);
    cycles(2);  chk("lit idle hold", int'(qA), 2);

`ifdef UPCNT_LOAD_EN
    loadA = 1'b1; dA = 4'd7; startA = 1'b1;
    cycles(1);  chk("lit load beats start", int'(qA), 7); chk("lit load stays idle", int'(busyA), 0);
    loadA = 1'b0; startA = 1'b0;
    cycles(2);  chk("lit load idle hold", int'(qA), 7);
    loadA = 1'b1; dA = 4'd12;
    cycles(1);  chk("lit load clamp", int'(qA), 9); chk("lit idle tc", int'(tcA), 0);
    loadA = 1'b0; startA = 1'b1;
    cycles(1);  chk("lit start after load", int'(qA), 0);
    startA = 1'b0;
    cycles(2);
    loadA = 1'b1; dA = 4'd12;
    cycles(1);  chk("lit load in run", int'(qA), 9); chk("lit load no done", int'(doneA), 0); chk("lit load run busy", int'(busyA), 1);
    loadA = 1'b0;
    cycles(1);  chk("lit done after load", int'(doneA), 1);
    modeA = 1'b0; tA = 1'b0; loadA = 1'b1; dA = 4'd5;
    cycles(1);  chk("lit load paused", int'(qA), 5);
    loadA = 1'b0;
    cycles(2);  chk("lit load paused hold", int'(qA), 5);
    tA = 1'b1;
    cycles(1);  chk("lit load then count", int'(qA), 6);
`endif

    cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog at %0t: got no finish, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
